// File: rtl/best_neighbor_search_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : best_neighbor_search_if                                          |
// | Brief   : Start/result handshake and byte-memory read bus of the search.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface best_neighbor_search_if #(
  parameter int ADDR_W = 10
);
  logic              i_start;
  logic              o_mem_rd_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        i_mem_data_in;
  logic              o_busy;
  logic              o_done;
  logic              o_empty;
  logic [15:0]       o_bestvalue;
  logic [15:0]       o_bestneighborID;
  logic [15:0]       o_besthop;

  modport master (
    output i_start, i_mem_data_in,
    input  o_mem_rd_en, o_mem_addr, o_busy, o_done, o_empty,
           o_bestvalue, o_bestneighborID, o_besthop
  );

  modport slave (
    input  i_start, i_mem_data_in,
    output o_mem_rd_en, o_mem_addr, o_busy, o_done, o_empty,
           o_bestvalue, o_bestneighborID, o_besthop
  );
endinterface
`default_nettype wire

// File: rtl/best_neighbor_search.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : best_neighbor_search                                             |
// | Brief   : Scans a byte-wide neighbour table for the largest binary16 Q.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module best_neighbor_search #(
  parameter int                ADDR_W        = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                MAX_NEIGHBORS = 16
) (
  input logic                   clock,
  input logic                   nreset,
  best_neighbor_search_if.slave bus
);

  localparam int c_NW = $clog2(MAX_NEIGHBORS + 1);
  localparam int c_RW = $clog2(6 * MAX_NEIGHBORS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_CNT = 3'd1,
    S_CHK    = 3'd2,
    S_RD_ENT = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_rd_en;
  logic              w_busy;
  logic              w_done;

  logic [ADDR_W-1:0] r_addr;
  logic              r_dv;
  logic [7:0]        r_cnt_lo;
  logic [7:0]        r_hop_lo;
  logic [c_RW-1:0]   r_rd_left;
  logic [2:0]        r_bsel;
  logic [15:0]       r_ent_id;
  logic [15:0]       r_ent_q;
  logic [15:0]       r_best_q;
  logic [15:0]       r_best_id;
  logic [15:0]       r_best_hop;
  logic              r_have;
  logic              r_empty;

  logic [15:0]       w_cnt;
  logic [c_NW-1:0]   w_nclamp;
  logic [c_RW-1:0]   w_reads;
  logic              w_nan;
  logic              w_eval;
  logic              w_upd;

  // Monotonic key for sign-magnitude order; -0 folds onto +0 so they tie.
  function automatic logic [15:0] f_key(input logic [15:0] q);
    if (q[14:0] == 15'd0)
      return 16'h8000;
    else if (q[15])
      return {1'b0, ~q[14:0]};
    else
      return {1'b1, q[14:0]};
  endfunction

  assign w_cnt    = {bus.i_mem_data_in, r_cnt_lo};
  assign w_nclamp = (w_cnt > 16'(MAX_NEIGHBORS)) ? c_NW'(MAX_NEIGHBORS) : w_cnt[c_NW-1:0];
  assign w_reads  = c_RW'(w_nclamp) * c_RW'(6);
  assign w_nan    = (r_ent_q[14:10] == 5'h1F) && (r_ent_q[9:0] != 10'd0);
  assign w_eval   = (r_state == S_RD_ENT) && r_dv && (r_bsel == 3'd5);
  assign w_upd    = w_eval && !w_nan && (!r_have || (f_key(r_ent_q) > f_key(r_best_q)));

  always_ff @(posedge clock) begin
    if (!nreset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.i_start)
          w_state_nxt = S_RD_CNT;
      end
      S_RD_CNT: begin
        w_rd_en = 1'b1;
        if (r_dv)
          w_state_nxt = S_CHK;
      end
      S_CHK: begin
        w_state_nxt = (w_nclamp == '0) ? S_FINISH : S_RD_ENT;
      end
      S_RD_ENT: begin
        // Final cycle here issues no read; it only captures the last hop byte.
        w_rd_en = (r_rd_left != '0);
        if (r_rd_left == '0)
          w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_addr     <= '0;
      r_dv       <= 1'b0;
      r_cnt_lo   <= 8'd0;
      r_hop_lo   <= 8'd0;
      r_rd_left  <= '0;
      r_bsel     <= 3'd0;
      r_ent_id   <= 16'd0;
      r_ent_q    <= 16'd0;
      r_best_q   <= 16'hFC00;
      r_best_id  <= 16'hFFFF;
      r_best_hop <= 16'd0;
      r_have     <= 1'b0;
      r_empty    <= 1'b0;
    end else begin
      r_dv <= w_rd_en;
      if (w_rd_en)
        r_addr <= r_addr + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_addr     <= BASE_ADDR;
            r_best_q   <= 16'hFC00;
            r_best_id  <= 16'hFFFF;
            r_best_hop <= 16'd0;
            r_have     <= 1'b0;
            r_empty    <= 1'b0;
          end
        end
        S_RD_CNT: begin
          if (r_dv)
            r_cnt_lo <= bus.i_mem_data_in;
        end
        S_CHK: begin
          r_rd_left <= w_reads;
          r_bsel    <= 3'd0;
          if (w_nclamp == '0)
            r_empty <= 1'b1;
        end
        S_RD_ENT: begin
          if (w_rd_en)
            r_rd_left <= r_rd_left - 1'b1;
          if (r_dv) begin
            case (r_bsel)
              3'd0:    r_ent_id[7:0]  <= bus.i_mem_data_in;
              3'd1:    r_ent_id[15:8] <= bus.i_mem_data_in;
              3'd2:    r_ent_q[7:0]   <= bus.i_mem_data_in;
              3'd3:    r_ent_q[15:8]  <= bus.i_mem_data_in;
              3'd4:    r_hop_lo       <= bus.i_mem_data_in;
              default: ;
            endcase
            r_bsel <= (r_bsel == 3'd5) ? 3'd0 : r_bsel + 3'd1;
          end
          if (w_upd) begin
            r_best_q   <= r_ent_q;
            r_best_id  <= r_ent_id;
            r_best_hop <= {bus.i_mem_data_in, r_hop_lo};
            r_have     <= 1'b1;
          end
          if (r_rd_left == '0)
            r_empty <= !(r_have || w_upd);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mem_rd_en      = w_rd_en;
  assign bus.o_mem_addr       = r_addr;
  assign bus.o_busy           = w_busy;
  assign bus.o_done           = w_done;
  assign bus.o_empty          = r_empty;
  assign bus.o_bestvalue      = r_best_q;
  assign bus.o_bestneighborID = r_best_id;
  assign bus.o_besthop        = r_best_hop;

endmodule
`default_nettype wire

// File: tb/tb_best_neighbor_search.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_best_neighbor_search                                          |
// | Brief   : Table vectors plus scoreboard-checked scans of the search block. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_best_neighbor_search;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  best_neighbor_search_if #(.ADDR_W(10)) bus0 ();
  best_neighbor_search_if #(.ADDR_W(10)) bus1 ();

  best_neighbor_search #(.ADDR_W(10), .BASE_ADDR(10'h000), .MAX_NEIGHBORS(16)) u_dut0 (
    .clock(clock), .nreset(nreset), .bus(bus0)
  );
  best_neighbor_search #(.ADDR_W(10), .BASE_ADDR(10'h3FC), .MAX_NEIGHBORS(16)) u_dut1 (
    .clock(clock), .nreset(nreset), .bus(bus1)
  );

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];

  always @(posedge clock) begin
    if (bus0.o_mem_rd_en) bus0.i_mem_data_in <= mem0[bus0.o_mem_addr];
    if (bus1.o_mem_rd_en) bus1.i_mem_data_in <= mem1[bus1.o_mem_addr];
  end

  typedef struct {
    int          which;
    int          cyc;
    int          reads;
    logic [15:0] val;
    logic [15:0] id;
    logic [15:0] hop;
    logic        empty;
  } exp_t;

  typedef struct {
    logic [15:0]       cnt;
    logic [3:0][15:0]  id;
    logic [3:0][15:0]  q;
    logic [3:0][15:0]  hop;
    logic [15:0]       e_val;
    logic [15:0]       e_id;
    logic [15:0]       e_hop;
    logic              e_empty;
  } vec_t;

  exp_t sb[$];
  exp_t me;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   c0      = 0;
  int   rd0     = 0;
  int   rd1     = 0;
  logic saw_wrap = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (bus0.o_mem_rd_en) rd0++;
    if (bus1.o_mem_rd_en) begin
      rd1++;
      if (bus1.o_mem_addr == 10'h000) saw_wrap = 1'b1;
    end
    if (nreset && (bus0.o_done || bus1.o_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = sb.pop_front();
        if (me.which == 0) begin
          chk("done_dut0", bus0.o_done, 1);
          chk("bestvalue", bus0.o_bestvalue, me.val);
          chk("bestneighborID", bus0.o_bestneighborID, me.id);
          chk("besthop", bus0.o_besthop, me.hop);
          chk("empty", bus0.o_empty, me.empty);
          chk("read_count", rd0, me.reads);
        end else begin
          chk("done_dut1", bus1.o_done, 1);
          chk("bestvalue_w", bus1.o_bestvalue, me.val);
          chk("bestneighborID_w", bus1.o_bestneighborID, me.id);
          chk("besthop_w", bus1.o_besthop, me.hop);
          chk("empty_w", bus1.o_empty, me.empty);
          chk("read_count_w", rd1, me.reads);
        end
        chk("done_cycle", cyc - c0 + 1, me.cyc);
      end
    end
  end

  task automatic wr(input int which, input int addr, input logic [15:0] v);
    logic [9:0] a;
    a = 10'(addr);
    if (which == 0) begin
      mem0[a] = v[7:0];
      mem0[a + 10'd1] = v[15:8];
    end else begin
      mem1[a] = v[7:0];
      mem1[a + 10'd1] = v[15:8];
    end
  endtask

  function automatic logic [15:0] rd16(input int which, input int addr);
    logic [9:0] a;
    a = 10'(addr);
    return (which == 0) ? {mem0[a + 10'd1], mem0[a]} : {mem1[a + 10'd1], mem1[a]};
  endfunction

  task automatic put_entry(input int which, input int base, input int idx,
                           input logic [15:0] id, input logic [15:0] q, input logic [15:0] hop);
    wr(which, base + 2 + 6 * idx, id);
    wr(which, base + 4 + 6 * idx, q);
    wr(which, base + 6 + 6 * idx, hop);
  endtask

  task automatic poison(input int which, input int base);
    for (int i = 0; i < 40; i++) put_entry(which, base, i, 16'hEEEE, 16'h7BFF, 16'hEEEE);
  endtask

  // a > b in binary16 value order, NaN excluded by the caller, zeros equal
  function automatic logic gt(input logic [15:0] a, input logic [15:0] b);
    logic az, bz;
    az = (a[14:0] == 15'd0);
    bz = (b[14:0] == 15'd0);
    if (az && bz) return 1'b0;
    if (az) return b[15];
    if (bz) return !a[15];
    if (a[15] != b[15]) return !a[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  function automatic exp_t model(input int which, input int base);
    exp_t        e;
    int          n;
    logic [15:0] q;
    logic        have;
    n = int'(rd16(which, base));
    if (n > 16) n = 16;
    e.which = which;
    e.val = 16'hFC00;
    e.id = 16'hFFFF;
    e.hop = 16'h0000;
    have = 1'b0;
    for (int i = 0; i < n; i++) begin
      q = rd16(which, base + 4 + 6 * i);
      if (!((q[14:10] == 5'h1F) && (q[9:0] != 10'd0))) begin
        if (!have || gt(q, e.val)) begin
          e.val = q;
          e.id = rd16(which, base + 2 + 6 * i);
          e.hop = rd16(which, base + 6 + 6 * i);
          have = 1'b1;
        end
      end
    end
    e.empty = !have;
    e.cyc = (n == 0) ? 4 : 5 + 6 * n;
    e.reads = 2 + 6 * n;
    return e;
  endfunction

  // Caller must be at a negedge; start is sampled at the following posedge.
  task automatic launch(input int which, input exp_t e);
    if (which == 0) bus0.i_start = 1'b1;
    else bus1.i_start = 1'b1;
    @(posedge clock);
    #1;
    bus0.i_start = 1'b0;
    bus1.i_start = 1'b0;
    c0 = cyc;
    rd0 = 0;
    rd1 = 0;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      chk("scan_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic load_vec(input vec_t v);
    poison(0, 0);
    wr(0, 0, v.cnt);
    for (int i = 0; i < 4; i++)
      if (i < int'(v.cnt)) put_entry(0, 0, i, v.id[i], v.q[i], v.hop[i]);
  endtask

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    int   n;
    n = int'(v.cnt);
    e.which = 0;
    e.val = v.e_val;
    e.id = v.e_id;
    e.hop = v.e_hop;
    e.empty = v.e_empty;
    e.cyc = (n == 0) ? 4 : 5 + 6 * n;
    e.reads = 2 + 6 * n;
    return e;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, bus0.o_mem_rd_en, 0);
    chk({tag, "_addr"}, bus0.o_mem_addr, 0);
    chk({tag, "_busy"}, bus0.o_busy, 0);
    chk({tag, "_done"}, bus0.o_done, 0);
    chk({tag, "_empty"}, bus0.o_empty, 0);
    chk({tag, "_val"}, bus0.o_bestvalue, 16'hFC00);
    chk({tag, "_id"}, bus0.o_bestneighborID, 16'hFFFF);
    chk({tag, "_hop"}, bus0.o_besthop, 0);
  endtask

  vec_t vt [8];
  exp_t e;
  logic [15:0] rq;
  int   seen;

  initial begin
    vt[0] = '{cnt:16'd3, id:{16'h0, 16'h2, 16'h9, 16'h5}, q:{16'h0, 16'h3800, 16'h4000, 16'h3C00},
              hop:{16'h0, 16'h1, 16'h2, 16'h1}, e_val:16'h4000, e_id:16'h9, e_hop:16'h2, e_empty:1'b0};
    vt[1] = '{cnt:16'd0, id:'0, q:'0, hop:'0, e_val:16'hFC00, e_id:16'hFFFF, e_hop:16'h0, e_empty:1'b1};
    vt[2] = '{cnt:16'd4, id:{16'h4, 16'h3, 16'h2, 16'h1}, q:{16'h8000, 16'h4000, 16'h4000, 16'hBC00},
              hop:{16'd13, 16'd12, 16'd11, 16'd10}, e_val:16'h4000, e_id:16'h2, e_hop:16'd11, e_empty:1'b0};
    vt[3] = '{cnt:16'd2, id:{16'h0, 16'h0, 16'h8, 16'h7}, q:{16'h0, 16'h0, 16'h8000, 16'h0000},
              hop:{16'h0, 16'h0, 16'h4, 16'h3}, e_val:16'h0000, e_id:16'h7, e_hop:16'h3, e_empty:1'b0};
    vt[4] = '{cnt:16'd2, id:{16'h0, 16'h0, 16'h8, 16'h7}, q:{16'h0, 16'h0, 16'h0000, 16'h8000},
              hop:{16'h0, 16'h0, 16'h4, 16'h3}, e_val:16'h8000, e_id:16'h7, e_hop:16'h3, e_empty:1'b0};
    vt[5] = '{cnt:16'd2, id:{16'h0, 16'h0, 16'h2, 16'h1}, q:{16'h0, 16'h0, 16'hBC00, 16'h7E00},
              hop:{16'h0, 16'h0, 16'h5, 16'h9}, e_val:16'hBC00, e_id:16'h2, e_hop:16'h5, e_empty:1'b0};
    vt[6] = '{cnt:16'd2, id:{16'h0, 16'h0, 16'h2, 16'h1}, q:{16'h0, 16'h0, 16'hFC01, 16'h7E00},
              hop:{16'h0, 16'h0, 16'h5, 16'h9}, e_val:16'hFC00, e_id:16'hFFFF, e_hop:16'h0, e_empty:1'b1};
    vt[7] = '{cnt:16'd1, id:{16'h0, 16'h0, 16'h0, 16'h3}, q:{16'h0, 16'h0, 16'h0, 16'hFC00},
              hop:{16'h0, 16'h0, 16'h0, 16'h6}, e_val:16'hFC00, e_id:16'h3, e_hop:16'h6, e_empty:1'b0};

    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    bus0.i_start = 1'b0;
    bus1.i_start = 1'b0;
    nreset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      load_vec(vt[v]);
      @(negedge clock);
      launch(0, vec_exp(vt[v]));
      wait_idle(200);
    end

    // start while busy is ignored; start in the done cycle too; the next cycle starts
    load_vec(vt[0]);
    e = vec_exp(vt[0]);
    @(negedge clock);
    launch(0, e);
    repeat (4) @(negedge clock);
    bus0.i_start = 1'b1;
    @(negedge clock);
    bus0.i_start = 1'b0;
    for (int i = 0; i < 100 && !bus0.o_done; i++) @(negedge clock);
    chk("busy_at_done", bus0.o_busy, 1);
    bus0.i_start = 1'b1;
    @(negedge clock);
    chk("busy_after_done", bus0.o_busy, 0);
    launch(0, e);
    wait_idle(200);
    repeat (3) @(negedge clock);
    chk("hold_val", bus0.o_bestvalue, 16'h4000);
    chk("hold_id", bus0.o_bestneighborID, 16'h9);

    // count above the clamp; entries past index 15 would win if read
    poison(0, 0);
    wr(0, 0, 16'd40);
    for (int i = 0; i < 40; i++)
      put_entry(0, 0, i, 16'(i), (i < 16) ? 16'(16'h3C00 + i) : 16'h7BFF, 16'(100 + i));
    e = model(0, 0);
    @(negedge clock);
    launch(0, e);
    wait_idle(300);

    // table straddling the top of the address space
    poison(1, 10'h3FC);
    wr(1, 10'h3FC, 16'd2);
    put_entry(1, 10'h3FC, 0, 16'h0011, 16'h3C00, 16'h0001);
    put_entry(1, 10'h3FC, 1, 16'h0022, 16'h4400, 16'h0002);
    e = model(1, 10'h3FC);
    saw_wrap = 1'b0;
    @(negedge clock);
    launch(1, e);
    wait_idle(200);
    chk("addr_wrap", saw_wrap, 1);

    for (int r = 0; r < 8; r++) begin
      wr(0, 0, 16'($urandom_range(0, 6)));
      for (int i = 0; i < 20; i++) begin
        rq = 16'($urandom);
        case ($urandom_range(0, 5))
          0: rq = {rq[15], 5'h1F, rq[9:0] | 10'h001};
          1: rq = {rq[15], 15'h0000};
          2: rq = {rq[15], 5'h1F, 10'h000};
          3: rq = {rq[15], 5'h0F, rq[9:8], 8'h00};
          default: ;
        endcase
        put_entry(0, 0, i, 16'($urandom), rq, 16'($urandom));
      end
      e = model(0, 0);
      @(negedge clock);
      launch(0, e);
      wait_idle(200);
    end

    // reset in the middle of a scan
    load_vec(vt[0]);
    @(negedge clock);
    bus0.i_start = 1'b1;
    @(posedge clock);
    #1;
    bus0.i_start = 1'b0;
    repeat (9) @(negedge clock);
    nreset = 1'b0;
    @(posedge clock);
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    nreset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus0.o_done) seen = 1;
    end
    chk("no_done_after_reset", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
